// File: rtl/fifo_stream_arbiter.sv
// fifo_stream_arbiter: round-robin merge of N_SRC first-word-fall-through
// source FIFOs into one registered output stream with bounded bursts.
// Optional build macro ARB_SOURCE_TAG_EN: replaces the top 3 bits of each
// output word with the index of the source it came from.
module fifo_stream_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic [N_SRC-1:0]            SRC_EMPTY,
  input  logic [N_SRC*DATA_WIDTH-1:0] SRC_DATA,
  output logic [N_SRC-1:0]            SRC_READ,
  input  logic                        OUT_READY,
  output logic                        OUT_WRITE,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic [N_SRC-1:0]            GRANT,
  output logic                        BUSY
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_SRC - 1);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t                  state_q, state_d;
  logic [N_SRC-1:0]        grant_q, grant_d;
  // Index of the current grant while busy; doubles as the round-robin
  // "last granted" pointer while idle.
  logic [IDX_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    out_write_q, out_write_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic [DATA_WIDTH-1:0]   src_word [N_SRC];
  logic [DATA_WIDTH-1:0]   cur_word;
  logic                    any_req;
  logic                    found;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W-1:0]        cand_idx;
  int                      cand;
  logic                    pop;

  for (genvar i = 0; i < N_SRC; i++) begin : g_slice
    assign src_word[i] = SRC_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cur_word = src_word[last_q];
  assign any_req  = |(~SRC_EMPTY);

  // Rotating priority scan: first non-empty source after the last granted one.
  always_comb begin
    found    = 1'b0;
    sel_idx  = last_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      cand_idx = IDX_W'(cand);
      if (!found && !SRC_EMPTY[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  // Next-state, pop strobe and output-register load for the grant FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    count_d     = count_q;
    out_write_d = 1'b0;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    SRC_READ    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d          = ST_GRANT;
          last_d           = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          count_d          = '0;
        end
      end
      ST_GRANT: begin
        pop = OUT_READY && !SRC_EMPTY[last_q];
        if (pop) begin
          SRC_READ[last_q] = 1'b1;
          out_write_d      = 1'b1;
`ifdef ARB_SOURCE_TAG_EN
          out_data_d       = {3'(last_q), cur_word[DATA_WIDTH-4:0]};
`else
          out_data_d       = cur_word;
`endif
          count_d          = count_q + 1'b1;
          if (count_q == BURST_LAST) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (SRC_EMPTY[last_q]) begin
          // Source ran dry: release the grant, unused budget is dropped.
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop must not reach the source FIFO in a cycle that is being reset.
    if (BUS_RST) SRC_READ = '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge BUS_CLK) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (BUS_RST) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IDX_LAST;
      count_q     <= '0;
      out_write_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      count_q     <= count_d;
      out_write_q <= out_write_d;
      out_data_q  <= out_data_d;
    end
  end

  assign GRANT     = grant_q;
  assign OUT_WRITE = out_write_q;
  assign OUT_DATA  = out_data_q;
  assign BUSY      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// tb_fifo_stream_arbiter: directed and randomized checks of the round-robin
// FIFO stream arbiter against a transaction-level reference model.
module tb_fifo_stream_arbiter;

  localparam int N_SRC = 4;
  localparam int DW    = 32;
  localparam int MB    = 16;

`ifdef ARB_SOURCE_TAG_EN
  localparam logic [DW-1:0] TAG_EXP = 32'h6ABCDEF0;
`else
  localparam logic [DW-1:0] TAG_EXP = 32'h0ABCDEF0;
`endif

  logic                 bus_clk = 1'b0;
  logic                 bus_rst;
  logic [N_SRC-1:0]     src_empty;
  logic [N_SRC*DW-1:0]  src_data;
  logic [N_SRC-1:0]     src_read;
  logic                 out_ready;
  logic                 out_write;
  logic [DW-1:0]        out_data;
  logic [N_SRC-1:0]     grant;
  logic                 busy;

  fifo_stream_arbiter #(
    .N_SRC      (N_SRC),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .BUS_CLK   (bus_clk),
    .BUS_RST   (bus_rst),
    .SRC_EMPTY (src_empty),
    .SRC_DATA  (src_data),
    .SRC_READ  (src_read),
    .OUT_READY (out_ready),
    .OUT_WRITE (out_write),
    .OUT_DATA  (out_data),
    .GRANT     (grant),
    .BUSY      (busy)
  );

  always #5 bus_clk = ~bus_clk;

  // Source FIFO contents, expected and observed streams.
  logic [DW-1:0]    src_q [N_SRC][$];
  logic [DW-1:0]    exp_words[$];
  logic [DW-1:0]    obs_words[$];
  int               exp_grants[$];
  logic [N_SRC-1:0] obs_grants[$];
  int               exp_span, obs_span;
  int               tb_last;
  int               cyc, first_wr, last_wr, ready_mode;
  int               checks, failures;
  logic             prev_pop;
  logic [DW-1:0]    prev_word;
  logic [N_SRC-1:0] prev_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_out(input logic [DW-1:0] w, input int s);
    logic [DW-1:0] r;
    r = w;
`ifdef ARB_SOURCE_TAG_EN
    r[DW-1 -: 3] = 3'(s);
`endif
    return r;
  endfunction

  function automatic logic ready_val();
    case (ready_mode)
      1:       return ((cyc % 5) < 3);
      2:       return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N_SRC; i++) begin
      src_empty[i] = (src_q[i].size() == 0);
      if (src_q[i].size() != 0) src_data[i*DW +: DW] = src_q[i][0];
      else                      src_data[i*DW +: DW] = '0;
    end
  endtask

  task automatic load(input int s, input int n, input logic [DW-1:0] base, input bit rnd);
    for (int j = 0; j < n; j++) src_q[s].push_back(rnd ? DW'($urandom) : base + DW'(j));
    drive_srcs();
  endtask

  // Reference: with all words already queued, grants rotate from the last
  // granted source; each grant takes min(MB, remaining) words. A grant that
  // exhausts its budget costs one idle cycle, one that empties its source two.
  task automatic build_expect();
    int rem [N_SRC];
    int pos [N_SRC];
    int bursts[$];
    int total, p, s, n;
    exp_words.delete(); exp_grants.delete();
    total = 0;
    for (int i = 0; i < N_SRC; i++) begin
      rem[i] = src_q[i].size(); pos[i] = 0; total += rem[i];
    end
    p = tb_last;
    exp_span = total;
    while (total > 0) begin
      s = p;
      for (int k = 1; k <= N_SRC; k++) begin
        s = (p + k) % N_SRC;
        if (rem[s] > 0) break;
      end
      n = (rem[s] < MB) ? rem[s] : MB;
      for (int j = 0; j < n; j++) exp_words.push_back(exp_out(src_q[s][pos[s] + j], s));
      exp_grants.push_back(s);
      bursts.push_back(n);
      pos[s] += n; rem[s] -= n; total -= n; p = s;
    end
    for (int b = 0; b + 1 < bursts.size(); b++) exp_span += (bursts[b] == MB) ? 1 : 2;
    tb_last = p;
  endtask

  // One clock cycle: sample at the falling edge, apply pops after the rising edge.
  task automatic tick();
    logic [N_SRC-1:0] rd;
    int idx;
    @(negedge bus_clk);
    rd = src_read;
    check("read_onehot0", 64'($onehot0(rd)), 64'd1);
    check("read_legal", 64'(rd & (src_empty | {N_SRC{~out_ready}})), 64'd0);
    if (bus_rst) check("read_in_reset", 64'(rd), 64'd0);
    check("busy_vs_grant", 64'(busy), 64'(grant != '0));
    check("write_latency", 64'(out_write), 64'(prev_pop));
    if (prev_pop && out_write === 1'b1) check("write_data", 64'(out_data), 64'(prev_word));
    if (out_write === 1'b1) begin
      obs_words.push_back(out_data);
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (grant != '0 && grant != prev_grant) obs_grants.push_back(grant);
    prev_grant = grant;
    prev_pop = (rd != '0);
    idx = 0;
    for (int i = 0; i < N_SRC; i++) if (rd[i]) idx = i;
    if (prev_pop && src_q[idx].size() != 0) prev_word = exp_out(src_q[idx][0], idx);
    else                                    prev_word = 'x;
    @(posedge bus_clk); #1;
    if (prev_pop && src_q[idx].size() != 0) void'(src_q[idx].pop_front());
    cyc++;
    out_ready = ready_val();
    drive_srcs();
  endtask

  task automatic do_reset();
    bus_rst = 1'b1;
    repeat (2) @(posedge bus_clk);
    #1;
    @(negedge bus_clk);
    check("rst grant", 64'(grant), 64'd0);
    check("rst out_write", 64'(out_write), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst src_read", 64'(src_read), 64'd0);
    @(posedge bus_clk); #1;
    bus_rst    = 1'b0;
    prev_pop   = 1'b0;
    prev_grant = '0;
    tb_last    = N_SRC - 1;
  endtask

  task automatic run_stream(input string name, input int mode, input bit chk_span);
    int n, budget;
    build_expect();
    obs_words.delete(); obs_grants.delete();
    first_wr = -1; last_wr = -1;
    ready_mode = mode;
    out_ready  = ready_val();
    budget = 6 * (exp_words.size() + 2 * exp_grants.size()) + 20;
    n = 0;
    while (obs_words.size() < exp_words.size() && n < budget) begin
      tick();
      n++;
    end
    check({name, " in_budget"}, 64'(n < budget), 64'd1);
    repeat (4) tick();
    check({name, " word_count"}, 64'(obs_words.size()), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++)
      check($sformatf("%s word%0d", name, i), 64'(obs_words[i]), 64'(exp_words[i]));
    check({name, " grant_count"}, 64'(obs_grants.size()), 64'(exp_grants.size()));
    for (int i = 0; i < exp_grants.size() && i < obs_grants.size(); i++)
      check($sformatf("%s grant%0d", name, i), 64'(obs_grants[i]), 64'd1 << exp_grants[i]);
    obs_span = (first_wr < 0) ? 0 : last_wr - first_wr + 1;
    if (chk_span) check({name, " span"}, 64'(obs_span), 64'(exp_span));
    check({name, " idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, n;
    checks = 0; failures = 0; cyc = 0; ready_mode = 0;
    prev_pop = 1'b0; prev_grant = '0; prev_word = '0; tb_last = N_SRC - 1;
    first_wr = -1; last_wr = -1;
    bus_rst = 1'b1; out_ready = 1'b1;
    drive_srcs();
    do_reset();

    // Single source: bursts 16,16,8 with one gap cycle each.
    load(1, 40, 32'h100, 1'b0);
    run_stream("single", 0, 1'b1);
    check("single span_literal", 64'(obs_span), 64'd42);
    check("single grants_literal", 64'(obs_grants.size()), 64'd3);

    // All four sources full, 20 words each.
    do_reset();
    for (int s = 0; s < N_SRC; s++) load(s, 20, '0, 1'b1);
    run_stream("four", 0, 1'b1);
    check("four writes", 64'(obs_words.size()), 64'd80);
    for (int i = 0; i < 8; i++)
      check($sformatf("four order%0d", i),
            (i < obs_grants.size()) ? 64'(obs_grants[i]) : 64'hx, 64'd1 << (i % 4));

    // Backpressure on source 2: 3 ready / 2 stalled.
    do_reset();
    load(2, 12, '0, 1'b1);
    run_stream("backpressure", 1, 1'b0);
    check("backpressure one_grant", 64'(obs_grants.size()), 64'd1);

    // Source 0 runs dry mid-budget, then source 3; pointer must end on 3.
    do_reset();
    load(0, 5, 32'h500, 1'b0);
    load(3, 10, 32'h530, 1'b0);
    run_stream("mid_empty", 0, 1'b1);
    load(3, 2, 32'h5F0, 1'b0);
    load(0, 2, 32'h5E0, 1'b0);
    run_stream("after_empty", 0, 1'b1);
    check("after_empty first", (obs_grants.size() > 0) ? 64'(obs_grants[0]) : 64'hx, 64'd1);

    // Reset after 7 words of source 1.
    do_reset();
    load(1, 20, 32'h200, 1'b0);
    ready_mode = 0; out_ready = 1'b1;
    pops = 0; n = 0;
    while (pops < 7 && n < 50) begin
      tick();
      if (prev_pop) pops++;
      n++;
    end
    check("rst_mid pops", 64'(pops), 64'd7);
    load(0, 3, 32'h300, 1'b0);
    bus_rst = 1'b1;
    tick();
    bus_rst = 1'b0;
    @(negedge bus_clk);
    check("rst_mid grant", 64'(grant), 64'd0);
    check("rst_mid out_write", 64'(out_write), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    prev_grant = grant; prev_pop = 1'b0; cyc++;
    @(posedge bus_clk); #1;
    tb_last = N_SRC - 1;
    run_stream("post_reset", 0, 1'b1);
    check("post_reset first", (obs_grants.size() > 0) ? 64'(obs_grants[0]) : 64'hx, 64'd1);

    // Randomized depths, data and ready pattern.
    for (int it = 0; it < 3; it++) begin
      for (int s = 0; s < N_SRC; s++) load(s, int'($urandom_range(0, 25)), '0, 1'b1);
      run_stream($sformatf("random%0d", it), 2, 1'b0);
    end

    // Source tag on source 3.
    do_reset();
    src_q[3].push_back(32'h0ABCDEF0);
    drive_srcs();
    run_stream("tag", 0, 1'b1);
    check("tag literal", (obs_words.size() > 0) ? 64'(obs_words[0]) : 64'hx, 64'(TAG_EXP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_arbiter.md
Name: fifo_stream_arbiter

Overview:
- Round-robin arbiter that merges N first-word-fall-through (FWFT) source FIFOs into the single 32-bit output stream that feeds the BRAM output FIFO.
- Typical sources: chip data RX, TLU, TDC, timestamp.
- Sits between the receiver cores and the output-FIFO write interface in the core; replaces ad-hoc priority muxing.
- Bursts are bounded so that a busy source cannot starve the others.

Parameters:
- N_SRC, 4, number of source streams (2..8).
- DATA_WIDTH, 32, word width per source and on the output.
- MAX_BURST, 16, maximum words popped from one source per grant (1..256).

Ports:
- BUS_CLK  input  1  system clock; all logic in this domain.
- BUS_RST  input  1  synchronous active-high reset.
- SRC_EMPTY  input  N_SRC  per-source FWFT empty flag; SRC_DATA slice valid when low.
- SRC_DATA  input  N_SRC*DATA_WIDTH  flattened source words; source i at [i*DATA_WIDTH +: DATA_WIDTH].
- SRC_READ  output  N_SRC  per-source pop strobe; combinational, one-hot or zero.
- OUT_READY  input  1  downstream can accept a word this cycle (output FIFO not full).
- OUT_WRITE  output  1  registered write strobe, one cycle per word.
- OUT_DATA  output  DATA_WIDTH  registered word qualified by OUT_WRITE.
- GRANT  output  N_SRC  registered one-hot current grant; zero in IDLE.
- BUSY  output  1  high when not in IDLE.

Behaviour:
- Reset (sync, BUS_RST=1 at edge):
  - state=IDLE; GRANT=0; OUT_WRITE=0; OUT_DATA=0; burst count=0; last-granted pointer=N_SRC-1, so source 0 wins first.
  - SRC_READ=0 while BUS_RST is high.
- IDLE:
  - If any SRC_EMPTY[i]=0, select the first non-empty index scanning from last+1 with wrap-around modulo N_SRC.
  - Load GRANT, set last=selected, count=0, go to GRANT.
  - OUT_READY is not required to enter GRANT.
  - No pop happens in IDLE.
- GRANT (source g):
  - SRC_READ[g] = OUT_READY & ~SRC_EMPTY[g].
  - Each popped word appears on OUT_DATA with OUT_WRITE=1 exactly one cycle later (latency 1). Otherwise OUT_WRITE=0 and OUT_DATA holds its last value.
  - A pop increments count.
  - Go to IDLE on either of:
    - the pop that makes count reach MAX_BURST;
    - SRC_EMPTY[g]=1 with no pop.
  - OUT_READY=0 stalls in GRANT: no pop, count held, grant kept.
- Fairness:
  - Each source gets at most MAX_BURST consecutive words.
  - There is one IDLE cycle between grants, so worst-case wait for a source is (N_SRC-1)*(MAX_BURST+1) cycles of OUT_READY=1.
- Boundaries:
  - Only one source non-empty: it is re-granted repeatedly, with an IDLE gap every MAX_BURST words.
  - MAX_BURST=1 yields strict word interleave.
  - Source going empty mid-burst: grant released, remaining budget discarded.
  - Source becoming non-empty while it is not granted: waits its turn.
- Reset mid-burst: all state cleared on the next edge. A word in the output register is dropped (OUT_WRITE=0). A SRC_READ already asserted in the reset cycle is suppressed.
- Invariants:
  - At most one SRC_READ bit is high.
  - SRC_READ is never asserted while SRC_EMPTY or ~OUT_READY for that source.
  - Count width is clog2(MAX_BURST+1).

Optional Feature:
- Macro: ARB_SOURCE_TAG_EN.
- Defined: OUT_DATA[DATA_WIDTH-1 -: 3] is replaced by the granted source index (3 bits, zero-extended). The lower bits pass through unchanged. Requires DATA_WIDTH>=8.
- Undefined: OUT_DATA equals the popped source word bit-exact; no tag logic is synthesised.

Test Plan:
- Single source: reset, only source 1 holds 40 words 0x100..0x127, OUT_READY=1.
  - Expect words in order, each one cycle after its SRC_READ[1].
  - Expect bursts of 16, 16, 8, with exactly one OUT_WRITE=0 gap cycle between bursts.
- All four sources full, 20 words each, MAX_BURST=16, OUT_READY=1.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect first-round bursts of 16 words and second-round bursts of 4.
  - Expect 80 OUT_WRITE pulses and no SRC_READ overlap.
- Backpressure: source 2 streaming, OUT_READY toggled 3 high / 2 low.
  - Expect no SRC_READ[2] and no OUT_WRITE in the cycle after each low cycle.
  - Expect no lost or duplicated words and GRANT steady at 0b0100.
- Mid-burst empty: source 0 has 5 words, source 3 has 10.
  - Expect 5 words from source 0, then IDLE, then 10 words from source 3.
  - Expect last pointer=3 at the end, so source 0 is granted next.
- Reset mid-burst: assert BUS_RST for 1 cycle after 7 words of source 1.
  - Next cycle expect GRANT=0, OUT_WRITE=0, BUSY=0.
  - On release expect source 0 (if non-empty) granted first.
- With ARB_SOURCE_TAG_EN: source 3 word 0x0ABCDEF0 must appear as 0x6ABCDEF0 (3'b011 in bits [31:29]). Without the macro, the same stimulus must appear unchanged.
